// File: rtl/md_unit_v2.sv
// Multi-cycle multiply/divide unit with HI/LO registers and a busy/stall handshake.
// Define MD_MADD_EN to build the madd/maddu/msub/msubu accumulate ops (codes 7-10).
module md_unit_v2 #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LAT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LAT  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } md_op_t;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] pend_hi;
  logic [WIDTH-1:0] pend_lo;
  logic             pend_wr;

  logic [2*WIDTH-1:0] a_sx, b_sx, a_zx, b_zx;
  logic [2*WIDTH-1:0] prod_s, prod_u;

  assign a_sx   = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_sx   = {{WIDTH{b[WIDTH-1]}}, b};
  assign a_zx   = {{WIDTH{1'b0}}, a};
  assign b_zx   = {{WIDTH{1'b0}}, b};
  // Sign-extended operands give the exact signed product modulo 2^(2*WIDTH).
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  logic             a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag, dsr_s, dsr_u;
  logic [WIDTH-1:0] q_mag, r_mag, quo_s, rem_s, quo_u, rem_u;

  assign a_neg  = a[WIDTH-1];
  assign b_neg  = b[WIDTH-1];
  assign b_zero = (b == '0);
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;
  // Divisor forced non-zero so the datapath never divides by zero; the result is discarded anyway.
  assign dsr_s  = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
  assign dsr_u  = b_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
  assign q_mag  = a_mag / dsr_s;
  assign r_mag  = a_mag % dsr_s;
  assign quo_s  = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem_s  = a_neg ? -r_mag : r_mag;
  assign quo_u  = a / dsr_u;
  assign rem_u  = a % dsr_u;

`ifdef MD_MADD_EN
  logic [2*WIDTH-1:0] hilo;
  assign hilo = {hi, lo};
`endif

  logic             mc_op, op_mthi, op_mtlo, nxt_wr;
  logic [CW-1:0]    lat;
  logic [WIDTH-1:0] nxt_hi, nxt_lo;

  always_comb begin
    mc_op   = 1'b0;
    op_mthi = 1'b0;
    op_mtlo = 1'b0;
    nxt_wr  = 1'b0;
    lat     = '0;
    nxt_hi  = '0;
    nxt_lo  = '0;
    case (md_op)
      OP_MULT:  begin mc_op = 1'b1; lat = MULT_LAT; nxt_wr = 1'b1; {nxt_hi, nxt_lo} = prod_s; end
      OP_MULTU: begin mc_op = 1'b1; lat = MULT_LAT; nxt_wr = 1'b1; {nxt_hi, nxt_lo} = prod_u; end
      OP_DIV:   begin mc_op = 1'b1; lat = DIV_LAT; nxt_wr = ~b_zero; nxt_hi = rem_s; nxt_lo = quo_s; end
      OP_DIVU:  begin mc_op = 1'b1; lat = DIV_LAT; nxt_wr = ~b_zero; nxt_hi = rem_u; nxt_lo = quo_u; end
      OP_MTHI:  op_mthi = 1'b1;
      OP_MTLO:  op_mtlo = 1'b1;
`ifdef MD_MADD_EN
      OP_MADD:  begin mc_op = 1'b1; lat = MULT_LAT; nxt_wr = 1'b1; {nxt_hi, nxt_lo} = hilo + prod_s; end
      OP_MADDU: begin mc_op = 1'b1; lat = MULT_LAT; nxt_wr = 1'b1; {nxt_hi, nxt_lo} = hilo + prod_u; end
      OP_MSUB:  begin mc_op = 1'b1; lat = MULT_LAT; nxt_wr = 1'b1; {nxt_hi, nxt_lo} = hilo - prod_s; end
      OP_MSUBU: begin mc_op = 1'b1; lat = MULT_LAT; nxt_wr = 1'b1; {nxt_hi, nxt_lo} = hilo - prod_u; end
`endif
      default: ;
    endcase
  end

  assign stall = busy | (mc_op & ~req);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (~req && ~busy) begin
            if (op_mthi) hi <= a;
            if (op_mtlo) lo <= a;
            if (mc_op) begin
              pend_hi <= nxt_hi;
              pend_lo <= nxt_lo;
              pend_wr <= nxt_wr;
              cnt     <= lat;
              busy    <= 1'b1;
              state   <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (cnt == CNT_ONE) begin
            if (pend_wr) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit_v2.sv
// Self-checking bench for md_unit_v2 (WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10).
// Table of multi-cycle vectors plus hand-written sequences for req, blocking and reset.
module tb_md_unit_v2;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  md_op;
  logic [31:0] a, b;
  logic        req;
  logic [31:0] hi, lo;
  logic        busy, stall, done;

  always #5 clk = ~clk;

  md_unit_v2 #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .md_op(md_op), .a(a), .b(b), .req(req),
    .hi(hi), .lo(lo), .busy(busy), .stall(stall), .done(done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_hi, m_lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        keep;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_mc(input string nm, input logic [3:0] op, input logic [31:0] va,
                        input logic [31:0] vb, input logic keep, input logic [31:0] ehi,
                        input logic [31:0] elo, input int lat, input int req_cyc);
    exp_t e;
    int cnt;
    e.hi = keep ? m_hi : ehi;
    e.lo = keep ? m_lo : elo;
    md_op = op; a = va; b = vb; req = 1'b0;
    #1;
    check({nm, "_stall_pre"}, {31'b0, stall}, 32'd1);
    sb.push_back(e);
    step();
    md_op = 4'd0; a = $urandom; b = $urandom;
    cnt = 0;
    while (busy && cnt < 50) begin
      cnt++;
      if (cnt == 1) begin
        check({nm, "_lo_old"}, lo, m_lo);
        check({nm, "_hi_old"}, hi, m_hi);
        check({nm, "_stall_run"}, {31'b0, stall}, 32'd1);
        check({nm, "_done_run"}, {31'b0, done}, 32'd0);
      end
      if (cnt == req_cyc) req = 1'b1;
      step();
    end
    check({nm, "_busy_cycles"}, cnt, lat);
    check({nm, "_done"}, {31'b0, done}, 32'd1);
    e = sb.pop_front();
    check({nm, "_hi"}, hi, e.hi);
    check({nm, "_lo"}, lo, e.lo);
    m_hi = e.hi;
    m_lo = e.lo;
    req = 1'b0;
    step();
    check({nm, "_done_clear"}, {31'b0, done}, 32'd0);
  endtask

  task automatic mt(input string nm, input logic [3:0] op, input logic [31:0] val);
    md_op = op; a = val; req = 1'b0;
    #1;
    check({nm, "_stall"}, {31'b0, stall}, 32'd0);
    step();
    md_op = 4'd0;
    if (op == 4'd5) m_hi = val;
    else m_lo = val;
    check({nm, "_hi"}, hi, m_hi);
    check({nm, "_lo"}, lo, m_lo);
    check({nm, "_busy"}, {31'b0, busy}, 32'd0);
    step();
    check({nm, "_done"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    reset = 1'b1; md_op = 4'd0; a = '0; b = '0; req = 1'b0;
    step(); step();
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    repeat (10) step();
    check("idle_hi", hi, 32'd0);
    check("idle_lo", lo, 32'd0);
    check("idle_busy", {31'b0, busy}, 32'd0);
    check("idle_done", {31'b0, done}, 32'd0);
    check("idle_stall", {31'b0, stall}, 32'd0);

    vecs[0] = '{4'd1, 32'hFFFF_FFFE, 32'd3,          1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    vecs[1] = '{4'd3, 32'hFFFF_FFF9, 32'd2,          1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[2] = '{4'd3, 32'h8000_0000, 32'hFFFF_FFFF,  1'b0, 32'h0000_0000, 32'h8000_0000, 10};
    vecs[3] = '{4'd4, 32'd100,       32'd7,          1'b0, 32'd2,         32'd14,        10};
    vecs[4] = '{4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  1'b0, 32'hFFFF_FFFE, 32'h0000_0001, 5};
    vecs[5] = '{4'd4, 32'd5,         32'd0,          1'b1, 32'd0,         32'd0,         10};
    vecs[6] = '{4'd1, 32'd7,         32'hFFFF_FFFD,  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5};
    vecs[7] = '{4'd3, 32'd7,         32'hFFFF_FFFE,  1'b0, 32'd1,         32'hFFFF_FFFD, 10};
    for (int i = 0; i < 8; i++)
      run_mc($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].keep,
             vecs[i].hi, vecs[i].lo, vecs[i].lat, 0);

    md_op = 4'd2; a = 32'd3; b = 32'd4; req = 1'b1;
    #1;
    check("multu_req_stall", {31'b0, stall}, 32'd0);
    step();
    check("multu_req_busy", {31'b0, busy}, 32'd0);
    check("multu_req_hi", hi, m_hi);
    check("multu_req_lo", lo, m_lo);
    md_op = 4'd5; a = 32'hAAAA_5555;
    step();
    check("mthi_req_hi", hi, m_hi);
    md_op = 4'd0; req = 1'b0;
    step();
    check("req_done", {31'b0, done}, 32'd0);

    run_mc("multu_midreq", 4'd2, 32'd3, 32'd4, 1'b0, 32'd0, 32'd12, 5, 2);
    mt("mthi", 4'd5, 32'hDEAD_BEEF);
    mt("mtlo", 4'd6, 32'h0BAD_F00D);

    md_op = 4'd1; a = 32'd2; b = 32'd3;
    step();
    md_op = 4'd6; a = 32'h1234;
    cnt = 0;
    while (busy && cnt < 50) begin
      cnt++;
      step();
    end
    check("blk_busy_cycles", cnt, 32'd5);
    check("blk_lo_mult", lo, 32'd6);
    check("blk_hi_mult", hi, 32'd0);
    step();
    md_op = 4'd0;
    check("blk_lo_mtlo", lo, 32'h1234);
    m_hi = 32'd0; m_lo = 32'h1234;

    md_op = 4'd3; a = 32'd100; b = 32'd7;
    step();
    md_op = 4'd0;
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rstrun_hi", hi, 32'd0);
    check("rstrun_lo", lo, 32'd0);
    check("rstrun_busy", {31'b0, busy}, 32'd0);
    check("rstrun_done", {31'b0, done}, 32'd0);
    cnt = 0;
    repeat (12) begin
      step();
      if (done) cnt++;
    end
    check("rstrun_no_done", cnt, 32'd0);
    check("rstrun_lo_after", lo, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;

    mt("madd_sethi", 4'd5, 32'd0);
    mt("madd_setlo", 4'd6, 32'hFFFF_FFFF);
`ifdef MD_MADD_EN
    run_mc("maddu", 4'd8, 32'd1, 32'd1, 1'b0, 32'd1, 32'd0, 5, 0);
    run_mc("msub", 4'd9, 32'd1, 32'd1, 1'b0, 32'd0, 32'hFFFF_FFFF, 5, 0);
    run_mc("madd", 4'd7, 32'hFFFF_FFFF, 32'd2, 1'b0, 32'd0, 32'hFFFF_FFFD, 5, 0);
`else
    md_op = 4'd8; a = 32'd1; b = 32'd1;
    #1;
    check("maddu_off_stall", {31'b0, stall}, 32'd0);
    step();
    check("maddu_off_busy", {31'b0, busy}, 32'd0);
    md_op = 4'd0;
    step();
    check("maddu_off_done", {31'b0, done}, 32'd0);
    check("maddu_off_hi", hi, 32'd0);
    check("maddu_off_lo", lo, 32'hFFFF_FFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
